// File: rtl/exec_datapath_p.sv
// Execute-stage datapath: register file, 16-op ALU, carry/zero flags with an interrupt shadow copy.
// Define EXEC_DATAPATH_MUL_EN to build the iterative multiplier, HI register, busy_o and done_o.
module exec_datapath_p #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    localparam int SEL_W = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    input  logic              reg_wrt_i,
    input  logic              flag_we_i,
    input  logic [SEL_W-1:0]  rs_sel_i,
    input  logic [SEL_W-1:0]  rs2_sel_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic              op2_sel_i,
    input  logic [3:0]        alu_op_i,
    input  logic [1:0]        reg_mux_i,
    input  logic [DATA_W-1:0] data_dat_i,
    input  logic [DATA_W-1:0] port_dat_i,
    input  logic              flag_save_i,
    input  logic              flag_rest_i,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   regs [NREG];
    logic [DATA_W-1:0]   op2, alu_res, wb_dat, hi_q, mul_lo, mul_hi;
    logic [SEL_W-1:0]    mul_rd;
    logic                alu_c, carry_q, zero_q, carry_sh, zero_sh;
    logic                busy, mul_fin, mul_op;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] wide;
    logic [SH_W-1:0]     sh;

    // Register 0 is never written, so it always reads zero.
    assign rs_o    = regs[rs_sel_i];
    assign op2     = op2_sel_i ? regs[rs2_sel_i] : immed_i;
    assign sh      = immed_i[SH_W-1:0];
    assign res_o   = alu_res;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = '0;
        wide    = '0;
        case (alu_op_i)
            4'd0: begin
                sum = {1'b0, rs_o} + {1'b0, op2};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            4'd1: begin
                sum = {1'b0, rs_o} + {1'b0, op2} + {{DATA_W{1'b0}}, carry_q};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            // Subtraction wraps in DATA_W+1 bits, so the top bit is the borrow.
            4'd2: begin
                sum = {1'b0, rs_o} - {1'b0, op2};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            4'd3: begin
                sum = {1'b0, rs_o} - {1'b0, op2} - {{DATA_W{1'b0}}, carry_q};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            4'd4: alu_res = rs_o & op2;
            4'd5: alu_res = rs_o | op2;
            4'd6: alu_res = rs_o ^ op2;
            4'd7: alu_res = rs_o & ~op2;
            4'd8: begin
                wide    = {{DATA_W{1'b0}}, rs_o} << sh;
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            4'd9: begin
                wide    = {rs_o, {DATA_W{1'b0}}} >> sh;
                alu_res = wide[2*DATA_W-1:DATA_W];
                alu_c   = wide[DATA_W-1];
            end
            // Rotates: the last bit out lands at the opposite end of the result.
            4'd10: begin
                wide    = {rs_o, rs_o} << sh;
                alu_res = wide[2*DATA_W-1:DATA_W];
                alu_c   = (sh != '0) && wide[DATA_W];
            end
            4'd11: begin
                wide    = {rs_o, rs_o} >> sh;
                alu_res = wide[DATA_W-1:0];
                alu_c   = (sh != '0) && wide[DATA_W-1];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        wb_dat = alu_res;
        case (reg_mux_i)
            2'b01:   wb_dat = data_dat_i;
            2'b10:   wb_dat = port_dat_i;
            2'b11:   wb_dat = hi_q;
            default: wb_dat = alu_res;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (clk_en_i) begin
            if (mul_fin && mul_rd != '0)
                regs[mul_rd] <= mul_lo;
            else if (reg_wrt_i && !busy && !mul_op && rd_sel_i != '0)
                regs[rd_sel_i] <= wb_dat;
        end
    end

    // Restore beats a multiply completion, which beats an ordinary flag update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            carry_sh <= 1'b0;
            zero_sh  <= 1'b0;
        end else if (clk_en_i) begin
            if (flag_save_i) begin
                carry_sh <= carry_q;
                zero_sh  <= zero_q;
            end
            if (flag_rest_i) begin
                carry_q <= carry_sh;
                zero_q  <= zero_sh;
            end else if (mul_fin) begin
                carry_q <= |mul_hi;
                zero_q  <= ~|mul_lo;
            end else if (flag_we_i) begin
                carry_q <= alu_c;
                zero_q  <= ~|alu_res;
            end
        end
    end

`ifdef EXEC_DATAPATH_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand, prod_hi, prod_lo;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   acc_sum;

    // {prod_hi, prod_lo} starts as {0, multiplier}; each step adds and shifts right one bit.
    assign mul_op  = (alu_op_i == 4'd12);
    assign acc_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi  = acc_sum[DATA_W:1];
    assign mul_lo  = {acc_sum[0], prod_lo[DATA_W-1:1]};
    assign mul_fin = busy && (cnt == LAST);
    assign busy_o  = busy;
    assign done_o  = mul_fin;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            hi_q    <= '0;
            mul_rd  <= '0;
        end else if (clk_en_i) begin
            if (reg_wrt_i && mul_op && !busy) begin
                busy    <= 1'b1;
                cnt     <= '0;
                mcand   <= rs_o;
                prod_hi <= '0;
                prod_lo <= op2;
                mul_rd  <= rd_sel_i;
            end else if (busy) begin
                prod_hi <= mul_hi;
                prod_lo <= mul_lo;
                cnt     <= cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    hi_q <= mul_hi;
                end
            end
        end
    end
`else
    assign mul_op  = 1'b0;
    assign mul_fin = 1'b0;
    assign mul_lo  = '0;
    assign mul_hi  = '0;
    assign mul_rd  = '0;
    assign hi_q    = '0;
    assign busy    = 1'b0;
    assign busy_o  = 1'b0;
    assign done_o  = 1'b0;
`endif

endmodule

// File: doc/exec_datapath_p.md
EXEC_DATAPATH_P -- requirements
Module: exec_datapath_p

Interface
REQ-001 Parameter DATA_W, default 8: datapath, register and immediate width (legal 8, 16, 32).
REQ-002 Parameter NREG, default 8: register-file depth (power of two, 4..32); SEL_W = log2(NREG).
REQ-003 Port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  in  1  reset, asynchronous, active-low.
REQ-005 Port clk_en_i  in  1  global clock enable; low freezes all state.
REQ-006 Port reg_wrt_i  in  1  register-file write request.
REQ-007 Port flag_we_i  in  1  carry/zero flag update request.
REQ-008 Ports rs_sel_i, rs2_sel_i, rd_sel_i  in  SEL_W each  source, second-source and destination selects.
REQ-009 Port immed_i  in  DATA_W  immediate operand.
REQ-010 Port op2_sel_i  in  1  1 = rs2 operand, 0 = immed_i.
REQ-011 Port alu_op_i  in  4  ALU operation code.
REQ-012 Port reg_mux_i  in  2  write-back select: 00 ALU, 01 data_dat_i, 10 port_dat_i, 11 HI register.
REQ-013 Ports data_dat_i, port_dat_i  in  DATA_W each  memory and I/O read data.
REQ-014 Ports flag_save_i, flag_rest_i  in  1 each  interrupt flag shadow save and restore.
REQ-015 Port rs_o  out  DATA_W  rs read data; port res_o  out  DATA_W  ALU result.
REQ-016 Ports carry_o, zero_o  out  1 each  registered flags.
REQ-017 Ports busy_o, done_o  out  1 each  multiply in progress; one-cycle multiply completion.

Function
REQ-018 Register reads are combinational; register 0 reads zero and ignores writes.
REQ-019 Write occurs on an edge with clk_en_i & reg_wrt_i & !busy_o; a same-cycle read returns the old value.
REQ-020 alu_op_i: 0 add, 1 add+carry, 2 sub, 3 sub-borrow, 4 and, 5 or, 6 xor, 7 and-not, 8 shl, 9 shr, 10 rol, 11 ror, 12 mul, 13-15 result 0.
REQ-021 Add carry_o = carry-out; sub carry_o = borrow; logic ops carry_o = 0; shifts carry_o = last bit shifted out.
REQ-022 Shift count = low log2(DATA_W) bits of immed_i; count 0 passes rs unchanged and sets carry 0.
REQ-023 Carry-in for ops 1 and 3 is the registered carry flag.
REQ-024 Flags load on clk_en_i & flag_we_i; zero = (result == 0).
REQ-025 Flag priority: flag_rest_i over flag_we_i; flag_save_i captures the pre-edge flag values.
REQ-026 Multiply starts on an edge with clk_en_i & reg_wrt_i & alu_op_i==12 & !busy_o; operands and rd_sel are captured.
REQ-027 Multiply is an iterative shift-add: busy_o high for DATA_W enabled cycles after the start edge.
REQ-028 On the last cycle, done_o pulses; rd gets the low DATA_W bits, HI the high bits, zero = (low == 0), carry = (HI != 0).
REQ-029 While busy_o is high, new writes and multiply starts are ignored.
REQ-030 clk_en_i low stalls the multiply count without loss.

Reset
REQ-031 rst_i low immediately clears registers, flags, shadow flags, HI and multiply state; outputs go 0.
REQ-032 Reset during a multiply aborts it: no rd write and no done_o.

Configuration
REQ-033 Macro EXEC_DATAPATH_MUL_EN defined: multiplier, HI, busy_o and done_o are present per REQ-026..030.
REQ-034 Macro undefined: op 12 behaves as ops 13-15, busy_o and done_o are tied 0, and reg_mux_i 11 selects 0.

Verification (DATA_W=8, NREG=8)
REQ-035 add r0+immed 0x7F->r1, then r1+immed 0x01->r2 -> r2=0x80, carry 0, zero 0.
REQ-036 sub r0-immed 0x01 with flag_we -> result 0xFF, carry 1; then sub-borrow 0x05-0x01 -> 0x03.
REQ-037 mul 0xFF*0xFF->r3 -> busy_o 8 cycles; done_o one cycle; r3=0x01, HI=0xFE, carry 1.
REQ-038 rst_i low 4 cycles into mul -> busy_o 0 at once; r3 unchanged; done_o never high.
REQ-039 flags c=1,z=0, save, then flag_we result 0 (c=0,z=1), then restore -> c=1, z=0.
REQ-040 write 0xAA to r0 -> rs_o with rs_sel=0 reads 0x00.
